muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and counter sizing for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX
   } state_e;

   // Bits needed to count 0..n-1 (ceil(log2(n))), minimum 1.
   function automatic int unsigned log2(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: right-shifting shift-add multiply or one restoring-division quotient bit.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   input  logic               mul_bit,
   input  logic               div_bit,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH-1:0] rem_new;

   always_comb begin
      // Multiply: add multiplicand into the upper half, then shift the whole product right.
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mul_bit ? {1'b0, opnd} : '0);
      // Divide: upper half is the partial remainder, lower half collects quotient bits.
      rem_sh  = {acc[2*WIDTH-1:WIDTH], div_bit};
      diff    = rem_sh - {1'b0, opnd};
      fits    = (rem_sh >= {1'b0, opnd});
      rem_new = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      if (is_div) acc_next = {rem_new, acc[WIDTH-2:0], fits};
      else        acc_next = {sum, acc[WIDTH-1:1]};
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO; busy stalls the pipeline while in flight.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned   CW   = log2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e               state_q, state_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     shf_q, shf_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_p_q, neg_p_d;
   logic                 neg_r_q, neg_r_d;
   logic                 div0_q, div0_d;

   logic [2*WIDTH-1:0]   acc_next;
   logic                 sgn;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quot_fix, rem_fix;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (is_div_q),
      .acc      (acc_q),
      .opnd     (opnd_q),
      .mul_bit  (shf_q[0]),
      .div_bit  (shf_q[WIDTH-1]),
      .acc_next (acc_next)
   );

   always_comb begin
      sgn      = ~op[0];
      a_mag    = (sgn && a[WIDTH-1]) ? -a : a;
      b_mag    = (sgn && b[WIDTH-1]) ? -b : b;
      prod_fix = neg_p_q ? -acc_q : acc_q;
      quot_fix = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      state_d  = state_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      shf_d    = shf_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_p_d  = neg_p_q;
      neg_r_d  = neg_r_q;
      div0_d   = div0_q;

      case (state_q)
         ST_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               is_div_d = op[1];
               // Multiply iterates over the multiplier; divide shifts the dividend in MSB first.
               opnd_d   = op[1] ? b_mag : a_mag;
               shf_d    = op[1] ? a_mag : b_mag;
               neg_p_d  = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_r_d  = sgn && a[WIDTH-1] && op[1];
               div0_d   = op[1] && (b == '0);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            acc_d = acc_next;
            shf_d = is_div_q ? (shf_q << 1) : (shf_q >> 1);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) state_d = ST_FIX;
         end
         ST_FIX: begin
            if (is_div_q) begin
               // A zero divisor leaves |a| as the remainder, so sign fix-up restores a into HI.
               lo_d = div0_q ? '1 : quot_fix;
               hi_d = rem_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         shf_q    <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_p_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         shf_q    <= shf_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_p_q  <= neg_p_d;
         neg_r_q  <= neg_r_d;
         div0_q   <= div0_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: result table, busy/strobe-ignore sequence and mid-operation reset.
module tb_muldiv_unit;

   localparam int unsigned W = 32;

   logic         clk;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         hi_we, lo_we;
   logic [W-1:0] wdata;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int checks;
   int errors;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   vec_t vecs [13];

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where done is high, so consecutive calls are back-to-back.
   task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int lat;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      check({name, "_busy"}, 64'(busy), 64'd1);
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, 64'(lat), 64'd33);
      check({name, "_hi"}, 64'(hi), 64'(ehi));
      check({name, "_lo"}, 64'(lo), 64'(elo));
      check({name, "_busy_at_done"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt, done_cnt, done_at, hold_bad;
      logic [W-1:0] rhi, rlo;

      checks = 0; errors = 0;
      rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

      vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A};
      vecs[1]  = '{2'b00, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[2]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
      vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[4]  = '{2'b11, 32'd7,          32'd0,          32'h0000_0007, 32'hFFFF_FFFF};
      vecs[5]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
      vecs[6]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD};
      vecs[7]  = '{2'b11, 32'd100,        32'd7,          32'h0000_0002, 32'h0000_000E};
      vecs[8]  = '{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[9]  = '{2'b00, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
      vecs[10] = '{2'b01, 32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000};
      vecs[11] = '{2'b00, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h8000_0001};
      vecs[12] = '{2'b11, 32'hFFFF_FFFF,  32'd16,         32'h0000_000F, 32'h0FFF_FFFF};

      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_hi",   64'(hi),   64'd0);
      check("reset_lo",   64'(lo),   64'd0);
      rst = 1'b1;

      @(negedge clk);
      lo_we = 1'b1; wdata = 32'h55;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo_idle", 64'(lo), 64'h55);

      for (int i = 0; i < 13; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      end

      // MTHI in the same cycle as a MULTU start, then stray start/MTHI while busy.
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h1234; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
      @(negedge clk);
      hi_we = 1'b0; start = 1'b0;
      check("mthi_with_start", 64'(hi), 64'h1234);
      busy_cnt = 0; done_cnt = 0; done_at = -1; hold_bad = 0; rhi = '0; rlo = '0;
      for (int k = 0; k < 45; k++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin done_at = k; rhi = hi; rlo = lo; end
         end else if (done_cnt == 0 && hi !== 32'h1234) begin
            hold_bad++;
         end
         if (k == 10) begin start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7; hi_we = 1'b1; wdata = 32'hDEAD; end
         if (k == 11) begin start = 1'b0; hi_we = 1'b0; end
         @(negedge clk);
      end
      check("busy_cycles",   64'(busy_cnt), 64'd33);
      check("done_pulses",   64'(done_cnt), 64'd1);
      check("done_latency",  64'(done_at),  64'd33);
      check("hi_hold_count", 64'(hold_bad), 64'd0);
      check("seq_hi",        64'(rhi),      64'd0);
      check("seq_lo",        64'(rlo),      64'd9);
      check("seq_hi_after",  64'(hi),       64'd0);
      check("seq_lo_after",  64'(lo),       64'd9);

      // Reset in the middle of a MULT.
      hi_we = 1'b1; wdata = 32'hABCD;
      @(negedge clk);
      hi_we = 1'b0;
      start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi",   64'(hi),   64'd0);
      check("rst_lo",   64'(lo),   64'd9 & 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", 64'(busy), 64'd0);
      check("post_rst_lo",   64'(lo),   64'd0);
      run_op("after_rst", 2'b00, 32'd2, 32'd2, 32'd0, 32'd4);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
